fb_fill_dma: RTL and testbench
==============================

FB_FILL_DMA -- requirements
Module: fb_fill_dma

Interface
REQ-001 Reset rst, synchronous, active-high; clock clk.
REQ-002 Parameter BURST_BEATS, default 16, max beats per AXI write burst.
REQ-003 clk  in  1  system clock (100 MHz); rst  in  1  synchronous active-high reset.
REQ-004 io_bus_s_rd_en, io_bus_s_wr_en, io_bus_s_cs  in  1 each  MMIO strobes and chip select.
REQ-005 io_bus_s_address  in  32  register offset in [7:0]; io_bus_s_wr_data  in  32  write data.
REQ-006 io_bus_s_rd_data  out  32  registered read data.
REQ-007 axi_awaddr out 32, axi_awlen out 8, axi_awsize out 3, axi_awburst out 2, axi_awvalid out 1, axi_awready in 1  AXI write-address channel.
REQ-008 axi_wdata out 32, axi_wstrb out 4, axi_wlast out 1, axi_wvalid out 1, axi_wready in 1  AXI write-data channel.
REQ-009 axi_bresp in 2, axi_bvalid in 1, axi_bready out 1  AXI write-response channel.
REQ-010 AR/R channels tied off: arvalid=0, rready=1, all other AR outputs 0.
REQ-011 done_irq  out  1  one-cycle pulse when a fill completes.

Function
REQ-012 Registers, offsets from shared map: FILL_BASE (0x00), FILL_LEN in 32-bit words (0x04), FILL_COLOR (0x08), CTRL (0x0C), STATUS (0x10).
REQ-013 Writes to BASE/LEN/COLOR take effect only when not busy; writes while busy ignored.
REQ-014 BASE[5:0] forced to zero on write (64-byte alignment), so bursts never cross 4 KB.
REQ-015 CTRL write with bit0=1 in IDLE starts a fill; ignored while busy.
REQ-016 STATUS = {29'b0, error, done, busy}; read data valid one cycle after rd_en&cs; other offsets read 0.
REQ-017 done set at fill completion, cleared on start; error set on any bresp!=OKAY, cleared on start.
REQ-018 FSM states IDLE, ISSUE_ADDR, WRITE_DATA, WAIT_RESP; busy = state!=IDLE.
REQ-019 IDLE->ISSUE_ADDR on start with LEN!=0; start with LEN==0 sets done and pulses done_irq next cycle without bus traffic.
REQ-020 ISSUE_ADDR: awvalid=1, awlen=min(BURST_BEATS,remaining)-1, awsize=3'b010, awburst=INCR; on awready -> WRITE_DATA.
REQ-021 awvalid/awaddr/awlen held stable until awready.
REQ-022 WRITE_DATA: wvalid=1, wdata=FILL_COLOR, wstrb=4'hF; beat counted on wvalid&wready; wlast high on final beat only; after last beat -> WAIT_RESP.
REQ-023 W channel not driven before AW handshake completes (no write-before-address).
REQ-024 WAIT_RESP: bready=1; on bvalid, address += beats*4, remaining -= beats; remaining==0 -> IDLE with done, done_irq pulse; else -> ISSUE_ADDR.
REQ-025 remaining counter 24 bits; LEN[31:24] ignored.
REQ-026 Error does not abort; fill continues to completion.
REQ-027 Only one burst outstanding at any time.

Reset
REQ-028 On rst: state IDLE; awvalid, wvalid, wlast, done_irq = 0; BASE, LEN, COLOR, done, error = 0; rd_data = 0.
REQ-029 rst mid-burst abandons the transfer immediately; no completion pulse.

Structure
REQ-030 Register offsets MMIO_FBFILL_REG_* live in the shared memory-map package; FSM state typedef local to module.
REQ-031 No sub-module; single flat module.

Verification
REQ-032 BASE=0x1000, LEN=32, COLOR=0x00FF8040, start, zero-latency slave -> two 16-beat bursts at 0x1000, 0x1040, all wdata=0x00FF8040, done_irq once.
REQ-033 LEN=20 -> bursts awlen=15 then awlen=3 at base+0x40; wlast on beats 16 and 20.
REQ-034 awready held low 10 cycles, wready toggling -> awaddr/awlen stable, no wvalid before AW handshake, 20 total beats.
REQ-035 bresp=SLVERR on first burst -> fill completes, STATUS=0b110.
REQ-036 Start with LEN=0 -> no awvalid, done_irq next cycle; BASE write 0x1234 reads back 0x1200.
REQ-037 rst asserted mid-WRITE_DATA -> next cycle awvalid=wvalid=0, STATUS=0, no done_irq.

Source files
------------

// File: rtl/fb_fill_dma_pkg.sv
// Shared memory-map and AXI constants for the framebuffer fill DMA.
// Holds the MMIO register offsets (byte offsets within the block's
// 256-byte window) and the AXI encodings the engine drives or checks.
package fb_fill_dma_pkg;

   localparam logic [7:0] MMIO_FBFILL_REG_BASE   = 8'h00;
   localparam logic [7:0] MMIO_FBFILL_REG_LEN    = 8'h04;
   localparam logic [7:0] MMIO_FBFILL_REG_COLOR  = 8'h08;
   localparam logic [7:0] MMIO_FBFILL_REG_CTRL   = 8'h0C;
   localparam logic [7:0] MMIO_FBFILL_REG_STATUS = 8'h10;

   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

endpackage

// File: rtl/fb_fill_dma.sv
// Framebuffer fill DMA: writes FILL_LEN 32-bit words of FILL_COLOR starting
// at FILL_BASE using AXI INCR write bursts of up to BURST_BEATS beats, one
// burst outstanding at a time.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   io_bus_s_*            - MMIO slave (BASE/LEN/COLOR/CTRL/STATUS), rd_data registered
//   axi_aw*/axi_w*/axi_b* - AXI write master channels
//   axi_ar*/axi_rready    - AXI read channels, tied off
//   done_irq              - one-cycle pulse when a fill completes
module fb_fill_dma
   import fb_fill_dma_pkg::*;
#(
   parameter int unsigned BURST_BEATS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_bus_s_rd_en,
   input  logic        io_bus_s_wr_en,
   input  logic        io_bus_s_cs,
   input  logic [31:0] io_bus_s_address,
   input  logic [31:0] io_bus_s_wr_data,
   output logic [31:0] io_bus_s_rd_data,
   output logic [31:0] axi_awaddr,
   output logic [7:0]  axi_awlen,
   output logic [2:0]  axi_awsize,
   output logic [1:0]  axi_awburst,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        axi_wlast,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic [1:0]  axi_bresp,
   input  logic        axi_bvalid,
   output logic        axi_bready,
   output logic [31:0] axi_araddr,
   output logic [7:0]  axi_arlen,
   output logic [2:0]  axi_arsize,
   output logic [1:0]  axi_arburst,
   output logic        axi_arvalid,
   output logic        axi_rready,
   output logic        done_irq
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE_ADDR,
      ST_WRITE_DATA,
      ST_WAIT_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [31:0] len_q, len_d;
   logic [31:0] color_q, color_d;
   logic [31:0] addr_q, addr_d;
   logic [23:0] remaining_q, remaining_d;
   logic [8:0]  beat_cnt_q, beat_cnt_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        done_irq_q, done_irq_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic        wr_sel, rd_sel, busy, last_beat;
   logic [7:0]  reg_off;
   logic [8:0]  burst_beats;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^io_bus_s_address[31:8];

   always_comb begin
      wr_sel  = io_bus_s_cs & io_bus_s_wr_en;
      rd_sel  = io_bus_s_cs & io_bus_s_rd_en;
      reg_off = io_bus_s_address[7:0];
      busy    = (state_q != ST_IDLE);

      // Burst size is derived from remaining_q, which only changes in
      // WAIT_RESP, so AW fields and the wlast position stay stable for the
      // whole burst without a separate latch.
      if (remaining_q < 24'(BURST_BEATS)) burst_beats = remaining_q[8:0];
      else                                burst_beats = 9'(BURST_BEATS);
      last_beat = (beat_cnt_q == burst_beats - 9'd1);

      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      color_d     = color_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      beat_cnt_d  = beat_cnt_q;
      done_d      = done_q;
      error_d     = error_q;
      done_irq_d  = 1'b0;
      rd_data_d   = rd_data_q;

      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_wlast   = 1'b0;
      axi_bready  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_sel) begin
               unique case (reg_off)
                  MMIO_FBFILL_REG_BASE:  base_d  = {io_bus_s_wr_data[31:6], 6'b0};
                  MMIO_FBFILL_REG_LEN:   len_d   = io_bus_s_wr_data;
                  MMIO_FBFILL_REG_COLOR: color_d = io_bus_s_wr_data;
                  MMIO_FBFILL_REG_CTRL: begin
                     if (io_bus_s_wr_data[0]) begin
                        error_d = 1'b0;
                        if (len_q[23:0] != 24'd0) begin
                           done_d      = 1'b0;
                           addr_d      = base_q;
                           remaining_d = len_q[23:0];
                           state_d     = ST_ISSUE_ADDR;
                        end else begin
                           // Empty fill completes immediately with no bus traffic.
                           done_d     = 1'b1;
                           done_irq_d = 1'b1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_ISSUE_ADDR: begin
            axi_awvalid = 1'b1;
            if (axi_awready) begin
               beat_cnt_d = '0;
               state_d    = ST_WRITE_DATA;
            end
         end
         ST_WRITE_DATA: begin
            axi_wvalid = 1'b1;
            axi_wlast  = last_beat;
            if (axi_wready) begin
               if (last_beat) state_d = ST_WAIT_RESP;
               else           beat_cnt_d = beat_cnt_q + 9'd1;
            end
         end
         ST_WAIT_RESP: begin
            axi_bready = 1'b1;
            if (axi_bvalid) begin
               if (axi_bresp != AXI_RESP_OKAY) error_d = 1'b1;
               addr_d      = addr_q + {21'b0, burst_beats, 2'b00};
               remaining_d = remaining_q - {15'b0, burst_beats};
               if (remaining_q == {15'b0, burst_beats}) begin
                  done_d     = 1'b1;
                  done_irq_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  state_d = ST_ISSUE_ADDR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rd_sel) begin
         unique case (reg_off)
            MMIO_FBFILL_REG_BASE:   rd_data_d = base_q;
            MMIO_FBFILL_REG_LEN:    rd_data_d = len_q;
            MMIO_FBFILL_REG_COLOR:  rd_data_d = color_q;
            MMIO_FBFILL_REG_STATUS: rd_data_d = {29'b0, error_q, done_q, busy};
            default:                rd_data_d = '0;
         endcase
      end

      axi_awaddr  = addr_q;
      axi_awlen   = 8'(burst_beats - 9'd1);
      axi_awsize  = AXI_SIZE_4B;
      axi_awburst = AXI_BURST_INCR;
      axi_wdata   = color_q;
      axi_wstrb   = 4'hF;
      axi_araddr  = '0;
      axi_arlen   = '0;
      axi_arsize  = '0;
      axi_arburst = '0;
      axi_arvalid = 1'b0;
      axi_rready  = 1'b1;
      done_irq         = done_irq_q;
      io_bus_s_rd_data = rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         color_q     <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         beat_cnt_q  <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         done_irq_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         color_q     <= color_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         beat_cnt_q  <= beat_cnt_d;
         done_q      <= done_d;
         error_q     <= error_d;
         done_irq_q  <= done_irq_d;
         rd_data_q   <= rd_data_d;
      end
   end

endmodule

// File: tb/tb_fb_fill_dma.sv
module tb_fb_fill_dma;
   import fb_fill_dma_pkg::*;

   localparam int BB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0, wr_en = 1'b0, cs = 1'b0;
   logic [31:0] address = '0, wr_data = '0, rd_data;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready = 1'b0;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b0, bready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, rready, done_irq;

   fb_fill_dma #(.BURST_BEATS(BB)) dut (
      .clk(clk), .rst(rst),
      .io_bus_s_rd_en(rd_en), .io_bus_s_wr_en(wr_en), .io_bus_s_cs(cs),
      .io_bus_s_address(address), .io_bus_s_wr_data(wr_data), .io_bus_s_rd_data(rd_data),
      .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
      .axi_awvalid(awvalid), .axi_awready(awready),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
      .axi_wready(wready),
      .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
      .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
      .axi_arvalid(arvalid), .axi_rready(rready),
      .done_irq(done_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } burst_t;

   // Reference: list of bursts the fill should produce, plus slave state.
   burst_t      exp_q[$];
   int          mode = 0;          // 0 zero-latency, 1 random, 2 AW stall + wready toggle
   int          err_idx = -1;
   int          burst_idx = 0;
   int          irq_cnt = 0, beat_total = 0, aw_total = 0;
   logic [31:0] exp_color = '0;
   bit          inflight = 0, w_open = 0, b_pending = 0, prev_stall = 0;
   int          wbeat = 0, cur_len = 0, b_delay = 0, stall = 0;
   logic [31:0] prev_addr;
   logic [7:0]  prev_len;

   // AXI slave + protocol monitor. Inputs change on negedge, everything is
   // observed 1 ns later, i.e. exactly the values the next posedge sees.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0;
            inflight = 0; w_open = 0; b_pending = 0; prev_stall = 0; stall = 0;
            continue;
         end
         case (mode)
            0:       begin awready = 1'b1; wready = 1'b1; end
            2:       begin awready = (stall >= 10) ? 1'($urandom % 2) : 1'b0; wready = ~wready; end
            default: begin awready = 1'($urandom % 2); wready = 1'($urandom % 2); end
         endcase
         if (b_pending && b_delay == 0) begin
            bvalid = 1'b1;
            bresp  = (burst_idx == err_idx) ? 2'b10 : 2'b00;
         end else begin
            bvalid = 1'b0;
            if (b_pending) b_delay--;
         end
         #1;
         if (wvalid) begin
            chk("w_after_aw", 32'(w_open), 32'd1);
            if (wready) begin
               chk("wdata", wdata, exp_color);
               chk("wstrb", 32'(wstrb), 32'hF);
               chk("wlast", 32'(wlast), 32'(wbeat == cur_len));
               beat_total++;
               if (wbeat == cur_len) begin
                  w_open    = 0;
                  b_pending = 1;
                  b_delay   = (mode == 0) ? 0 : $urandom_range(0, 3);
               end else begin
                  wbeat++;
               end
            end
         end
         if (awvalid) begin
            chk("aw_single_outstanding", 32'(inflight), 32'd0);
            if (prev_stall) begin
               chk("aw_hold_addr", awaddr, prev_addr);
               chk("aw_hold_len", 32'(awlen), 32'(prev_len));
            end
            if (awready) begin
               aw_total++;
               chk("aw_size", 32'(awsize), 32'(3'b010));
               chk("aw_burst", 32'(awburst), 32'(2'b01));
               if (exp_q.size() == 0) begin
                  chk("aw_unexpected", 32'(exp_q.size() + 1), 32'd0);
               end else begin
                  burst_t e;
                  e = exp_q.pop_front();
                  chk("aw_addr", awaddr, e.addr);
                  chk("aw_len", 32'(awlen), 32'(e.len));
               end
               inflight = 1; w_open = 1; wbeat = 0; cur_len = int'(awlen);
               prev_stall = 0; stall = 0;
            end else begin
               prev_stall = 1; prev_addr = awaddr; prev_len = awlen; stall++;
            end
         end
         if (bvalid && bready) begin
            b_pending = 0; inflight = 0; burst_idx++;
         end
         if (done_irq) irq_cnt++;
      end
   end

   task automatic mmio_wr(input logic [7:0] off, input logic [31:0] d);
      @(negedge clk);
      cs = 1; wr_en = 1; address = {24'b0, off}; wr_data = d;
      @(negedge clk);
      cs = 0; wr_en = 0;
   endtask

   task automatic mmio_rd(input logic [7:0] off, output logic [31:0] d);
      @(negedge clk);
      cs = 1; rd_en = 1; address = {24'b0, off};
      @(negedge clk);
      cs = 0; rd_en = 0;
      #2 d = rd_data;
   endtask

   task automatic run_fill(input logic [31:0] base, input logic [31:0] len,
                           input logic [31:0] color, input int m, input int e,
                           input string tag);
      logic [31:0] b, rb;
      int rem, n, nb;
      burst_t bt;
      mode = m; err_idx = e; burst_idx = 0;
      irq_cnt = 0; beat_total = 0; aw_total = 0; exp_color = color;
      exp_q.delete();
      mmio_wr(MMIO_FBFILL_REG_BASE, base);
      mmio_wr(MMIO_FBFILL_REG_LEN, len);
      mmio_wr(MMIO_FBFILL_REG_COLOR, color);
      b = base & 32'hFFFF_FFC0;
      rem = int'(len[23:0]);
      nb = 0;
      while (rem > 0) begin
         n = (rem < BB) ? rem : BB;
         bt.addr = b; bt.len = 8'(n - 1);
         exp_q.push_back(bt);
         b += 32'(4 * n); rem -= n; nb++;
      end
      mmio_wr(MMIO_FBFILL_REG_CTRL, 32'd1);
      if (len[23:0] >= 8) begin
         mmio_rd(MMIO_FBFILL_REG_STATUS, rb);
         chk({tag, "_busy"}, 32'(rb[0]), 32'd1);
         mmio_wr(MMIO_FBFILL_REG_BASE, 32'hFFFF_FFC0);
         mmio_wr(MMIO_FBFILL_REG_COLOR, ~color);
         mmio_wr(MMIO_FBFILL_REG_CTRL, 32'd1);
      end
      for (int c = 0; c < 5000 && irq_cnt == 0; c++) @(negedge clk);
      chk({tag, "_done_seen"}, 32'(irq_cnt != 0), 32'd1);
      repeat (6) @(negedge clk);
      chk({tag, "_irq_once"}, 32'(irq_cnt), 32'd1);
      chk({tag, "_beats"}, 32'(beat_total), {8'b0, len[23:0]});
      chk({tag, "_bursts"}, 32'(aw_total), 32'(nb));
      chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      mmio_rd(MMIO_FBFILL_REG_STATUS, rb);
      chk({tag, "_status"}, rb, {29'b0, (e >= 0 && e < nb), 1'b1, 1'b0});
      mmio_rd(MMIO_FBFILL_REG_BASE, rb);
      chk({tag, "_base_kept"}, rb, base & 32'hFFFF_FFC0);
   endtask

   initial begin
      logic [31:0] rb, rl;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_wlast", 32'(wlast), 32'd0);
      chk("rst_irq", 32'(done_irq), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("arvalid", 32'(arvalid), 32'd0);
      chk("rready", 32'(rready), 32'd1);
      rst = 0;
      mmio_rd(MMIO_FBFILL_REG_STATUS, rb);
      chk("rst_status", rb, 32'd0);
      mmio_rd(MMIO_FBFILL_REG_COLOR, rb);
      chk("rst_color", rb, 32'd0);

      run_fill(32'h0000_1000, 32'd32, 32'h00FF_8040, 0, -1, "fill32");
      run_fill(32'h0000_1000, 32'd20, 32'h1234_5678, 0, -1, "fill20");
      run_fill(32'h0000_2000, 32'd20, 32'hA5A5_5A5A, 2, -1, "stall20");
      run_fill(32'h0000_3000, 32'd32, 32'hCAFE_F00D, 0, 0, "slverr");

      // Empty fill: no bus traffic, done_irq in the cycle after the CTRL write.
      mmio_wr(MMIO_FBFILL_REG_LEN, 32'd0);
      aw_total = 0; irq_cnt = 0;
      @(negedge clk);
      cs = 1; wr_en = 1; address = {24'b0, MMIO_FBFILL_REG_CTRL}; wr_data = 32'd1;
      @(negedge clk);
      cs = 0; wr_en = 0;
      #2 chk("len0_irq", 32'(done_irq), 32'd1);
      @(negedge clk);
      #2 chk("len0_irq_pulse", 32'(done_irq), 32'd0);
      repeat (5) @(negedge clk);
      chk("len0_no_aw", 32'(aw_total), 32'd0);
      chk("len0_irq_once", 32'(irq_cnt), 32'd1);
      mmio_rd(MMIO_FBFILL_REG_STATUS, rb);
      chk("len0_status", rb, 32'd2);
      mmio_wr(MMIO_FBFILL_REG_BASE, 32'h0000_1234);
      mmio_rd(MMIO_FBFILL_REG_BASE, rb);
      chk("base_align", rb, 32'h0000_1200);

      for (int i = 0; i < 8; i++) begin
         rl = $urandom;
         rl[23:0] = 24'($urandom_range(1, 70));
         run_fill($urandom, rl, $urandom, $urandom_range(0, 2),
                  $urandom_range(0, 4) - 1, $sformatf("rnd%0d", i));
      end

      // Reset in the middle of a data burst.
      mode = 1; err_idx = -1; burst_idx = 0; beat_total = 0; exp_color = 32'h0BAD_F00D;
      exp_q.delete();
      mmio_wr(MMIO_FBFILL_REG_BASE, 32'h0000_8000);
      mmio_wr(MMIO_FBFILL_REG_LEN, 32'd64);
      mmio_wr(MMIO_FBFILL_REG_COLOR, 32'h0BAD_F00D);
      for (int k = 0; k < 4; k++) begin
         burst_t bt;
         bt.addr = 32'h0000_8000 + 32'(k * 64); bt.len = 8'd15;
         exp_q.push_back(bt);
      end
      mmio_wr(MMIO_FBFILL_REG_CTRL, 32'd1);
      for (int c = 0; c < 2000 && beat_total < 3; c++) @(negedge clk);
      chk("rst_mid_reached", 32'(beat_total >= 3), 32'd1);
      @(negedge clk);
      rst = 1; irq_cnt = 0;
      @(negedge clk);
      #2;
      chk("rst_mid_awvalid", 32'(awvalid), 32'd0);
      chk("rst_mid_wvalid", 32'(wvalid), 32'd0);
      rst = 0;
      exp_q.delete();
      repeat (20) @(negedge clk);
      chk("rst_mid_no_irq", 32'(irq_cnt), 32'd0);
      mmio_rd(MMIO_FBFILL_REG_STATUS, rb);
      chk("rst_mid_status", rb, 32'd0);
      mmio_rd(MMIO_FBFILL_REG_BASE, rb);
      chk("rst_mid_base", rb, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=0x%08h exp=0x%08h", 32'd1, 32'd0);
      $fatal(1, "timeout");
   end

endmodule
